// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port memory between instruction fetch and data access.
// Data has priority; a streak counter bounds how long a pending fetch can be starved.
module mem_arbiter #(
  parameter int DATA_LEN     = 32,
  parameter int MEM_ADDR_LEN = 32,
  parameter int MAX_D_STREAK = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    if_req,
  input  logic [MEM_ADDR_LEN-1:0] if_addr,
  output logic                    if_ready,
  output logic [DATA_LEN-1:0]     if_rdata,
  input  logic                    d_req,
  input  logic                    d_we,
  input  logic [DATA_LEN/8-1:0]   d_be,
  input  logic [MEM_ADDR_LEN-1:0] d_addr,
  input  logic [DATA_LEN-1:0]     d_wdata,
  output logic                    d_ready,
  output logic [DATA_LEN-1:0]     d_rdata,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [DATA_LEN/8-1:0]   mem_be,
  output logic [MEM_ADDR_LEN-1:0] mem_addr,
  output logic [DATA_LEN-1:0]     mem_wdata,
  input  logic                    mem_ack,
  input  logic [DATA_LEN-1:0]     mem_rdata,
  output logic                    busy
);
  localparam int BW = DATA_LEN / 8;
  localparam int SW = $clog2(MAX_D_STREAK + 1);
  localparam logic [SW-1:0] SMAX = SW'(MAX_D_STREAK);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RESP} state_t;

  state_t                  state, state_nx;
  logic [SW-1:0]           streak, streak_nx;
  logic                    mem_req_nx, mem_we_nx;
  logic [BW-1:0]           mem_be_nx;
  logic [MEM_ADDR_LEN-1:0] mem_addr_nx;
  logic [DATA_LEN-1:0]     mem_wdata_nx;
  logic                    if_ready_nx, d_ready_nx;
  logic [DATA_LEN-1:0]     if_rdata_nx, d_rdata_nx;
  logic                    grant_d, grant_i;

  // A fetch that has waited out a full data streak wins the next slot.
  assign grant_d = d_req && !(if_req && streak == SMAX);
  assign grant_i = !grant_d && if_req;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      streak <= '0;
    end else begin
      state  <= state_nx;
      streak <= streak_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    streak_nx    = streak;
    mem_req_nx   = mem_req;
    mem_we_nx    = mem_we;
    mem_be_nx    = mem_be;
    mem_addr_nx  = mem_addr;
    mem_wdata_nx = mem_wdata;
    if_ready_nx  = 1'b0;
    d_ready_nx   = 1'b0;
    if_rdata_nx  = if_rdata;
    d_rdata_nx   = d_rdata;
    unique case (state)
      IDLE: begin
        unique case (1'b1)
          grant_d: begin
            state_nx     = BUSY_D;
            mem_req_nx   = 1'b1;
            mem_we_nx    = d_we;
            mem_be_nx    = d_be;
            mem_addr_nx  = d_addr;
            mem_wdata_nx = d_wdata;
            if (!if_req)
              streak_nx = '0;
            else if (streak != SMAX)
              streak_nx = streak + 1'b1;
          end
          grant_i: begin
            state_nx     = BUSY_I;
            mem_req_nx   = 1'b1;
            mem_we_nx    = 1'b0;
            mem_be_nx    = '1;
            mem_addr_nx  = if_addr;
            mem_wdata_nx = '0;
            streak_nx    = '0;
          end
          default: ;
        endcase
      end
      BUSY_I: begin
        if (mem_ack) begin
          state_nx    = RESP;
          mem_req_nx  = 1'b0;
          if_ready_nx = 1'b1;
          if_rdata_nx = mem_rdata;
        end
      end
      BUSY_D: begin
        if (mem_ack) begin
          state_nx   = RESP;
          mem_req_nx = 1'b0;
          d_ready_nx = 1'b1;
          if (!mem_we)
            d_rdata_nx = mem_rdata;
        end
      end
      RESP: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_ready  <= 1'b0;
      d_ready   <= 1'b0;
      if_rdata  <= '0;
      d_rdata   <= '0;
      busy      <= 1'b0;
    end else begin
      mem_req   <= mem_req_nx;
      mem_we    <= mem_we_nx;
      mem_be    <= mem_be_nx;
      mem_addr  <= mem_addr_nx;
      mem_wdata <= mem_wdata_nx;
      if_ready  <= if_ready_nx;
      d_ready   <= d_ready_nx;
      if_rdata  <= if_rdata_nx;
      d_rdata   <= d_rdata_nx;
      busy      <= (state_nx != IDLE);
    end
  end
endmodule
